key_expand_128: RTL
===================

// Module: key_expand_128
// PURPOSE
//  Iterative AES-128 key schedule. Loads a 128-bit cipher key and generates
//  round keys 0..10, one per clock. Each round runs RotWord on the last word,
//  then passes it through one SubByte_32 instance (dec tied 0, forward S-box).
//  It streams each round key to the round datapath and holds all 11 keys in a
//  register file, so decryption can read them back in reverse order.
// PARAMETERS
//  NR        10   number of rounds; fixed for AES-128, other values unsupported
//  IDX_W     4    width of round-key index ports
// PORTS
//  clk       in   1    single clock, rising edge
//  rst       in   1    asynchronous reset, active-high
//  start     in   1    one-cycle request: load key_in and begin expansion
//  key_in    in   128  cipher key, byte 0 at [127:120], sampled when start accepted
//  busy      out  1    expansion in progress
//  ready     out  1    all 11 round keys valid in store
//  rk_valid  out  1    rk_out/rk_idx valid this cycle (stream)
//  rk_idx    out  4    index 0..10 of the key on rk_out
//  rk_out    out  128  streamed round key
//  rd_idx    in   4    random-access read index
//  rd_key    out  128  stored round key[rd_idx], combinational read
// BEHAVIOUR
//  Reset (async, rst=1):
//   - State goes to IDLE. busy, ready, rk_valid, rk_idx and rk_out are all 0.
//   - All 11 key-store entries, the working key w, the round counter and rcon are cleared.
//  FSM has three states: IDLE, EXPAND, DONE.
//   - IDLE/DONE + start=1: accepted. w<=key_in, store[0]<=key_in, rk_out<=key_in,
//     rk_idx<=0, rk_valid<=1, round<=1, rcon<=8'h01, ready<=0, busy<=1. Go to EXPAND.
//   - EXPAND: each cycle computes next from w and writes store[round]<=next,
//     w<=next, rk_out<=next, rk_idx<=round, rk_valid<=1, rcon<=xtime(rcon).
//     xtime: {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
//   - EXPAND with round==NR: after the write, go to DONE with busy<=0, ready<=1.
//   - EXPAND + start=1: start is ignored. There is no abort and no queueing.
//  rk_valid is high for exactly 11 consecutive cycles per expansion (idx 0..10).
//   It is 0 in IDLE and DONE except on the accept cycle's output.
//  Next-key datapath (combinational). w = {w0,w1,w2,w3}, w0 at [127:96].
//   - t  = SubByte_32({w3[23:0],w3[31:24]}) ^ {rcon,24'h0}
//   - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
//  Rcon sequence for rounds 1..10: 01 02 04 08 10 20 40 80 1b 36.
//  Timing: start sampled at edge E.
//   - rk0 appears on rk_out after E. rk_n appears after E+n.
//   - ready=1 and busy=0 after edge E+10. Total latency is 11 cycles.
//  rd_key = store[rd_idx] when rd_idx<=10. rd_idx 11..15 returns 128'h0.
//   - Reads are valid while ready=1.
//   - During EXPAND, entries not yet written hold the previous key's values or 0.
//  Restart from DONE: ready drops the cycle after accept. The store is overwritten in place.
//  Reset mid-EXPAND: the store is cleared immediately. A new start is required after rst falls.
//  start held high continuously: re-accepted on every DONE cycle. Expansions run back to back.
// TESTING
//  1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
//     - rk_idx1 = a0fafe1788542cb123a339392a6c7605
//     - rk_idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
//     - ready rises 11 cycles after start
//  2. All-zero key:
//     - rk1 = 62636363626363636263636362636363
//     - rk10 = b4ef5bcb3e92e21123e951cf6f8f188e
//     - rd_idx sweep 10..0 matches the streamed values
//  3. start pulsed again at round 4 of EXPAND:
//     - ignored; sequence and rk10 unchanged
//     - rk_valid count = 11
//  4. rst asserted at round 6:
//     - all outputs 0 the same cycle
//     - rd_key=0 for every idx
//     - next start gives the correct full sequence
//  5. Back-to-back: zero key, then FIPS key started the first DONE cycle:
//     - ready low for 11 cycles
//     - final store holds the FIPS schedule
//  6. rd_idx=11..15 while ready -> rd_key=0

Source files
------------

// File: rtl/key_expand_128.sv
// Iterative AES-128 key schedule: one round key per clock, streamed out and kept
// in an 11-entry register file for reverse-order reads during decryption.

module sub_byte_32 (
    input  logic [31:0] data,
    input  logic        dec,
    output logic [31:0] result
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 naturally).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x14  = gf_mul(x12, x2);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(x240, x14);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [7:0] s;
        s = gf_inv(b);
        return s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign result[gi*8 +: 8] = dec ? inv_sbox(data[gi*8 +: 8]) : fwd_sbox(data[gi*8 +: 8]);
        end
    endgenerate
endmodule

module key_expand_128 #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [127:0]     key_in,
    output logic             busy,
    output logic             ready,
    output logic             rk_valid,
    output logic [IDX_W-1:0] rk_idx,
    output logic [127:0]     rk_out,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [127:0]     rd_key
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

    state_t             state_reg, state_next;
    logic [127:0]       store_reg [0:NR];
    logic [127:0]       w_reg;
    logic [IDX_W-1:0]   round_reg;
    logic [7:0]         rcon_reg;
    logic [127:0]       rk_out_reg;
    logic [IDX_W-1:0]   rk_idx_reg;
    logic               rk_valid_reg, busy_reg, ready_reg;
    logic               load, step;

    logic [31:0] w0, w1, w2, w3, sub_word, t_word, n0, n1, n2, n3;
    logic [127:0] next_key;
    logic [7:0]   rcon_next;

    assign {w0, w1, w2, w3} = w_reg;

    sub_byte_32 u_sub (
        .data   ({w3[23:0], w3[31:24]}),
        .dec    (1'b0),
        .result (sub_word)
    );

    assign t_word    = sub_word ^ {rcon_reg, 24'h0};
    assign n0        = w0 ^ t_word;
    assign n1        = w1 ^ n0;
    assign n2        = w2 ^ n1;
    assign n3        = w3 ^ n2;
    assign next_key  = {n0, n1, n2, n3};
    assign rcon_next = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            EXPAND: begin
                step = 1'b1;
                if (round_reg == LAST_IDX) state_next = DONE;
            end
            default: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = EXPAND;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) store_reg[i] <= '0;
            w_reg        <= '0;
            round_reg    <= '0;
            rcon_reg     <= '0;
            rk_out_reg   <= '0;
            rk_idx_reg   <= '0;
            rk_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            ready_reg    <= 1'b0;
        end else begin
            rk_valid_reg <= load | step;
            if (load) begin
                w_reg        <= key_in;
                store_reg[0] <= key_in;
                rk_out_reg   <= key_in;
                rk_idx_reg   <= '0;
                round_reg    <= IDX_W'(1);
                rcon_reg     <= 8'h01;
                ready_reg    <= 1'b0;
                busy_reg     <= 1'b1;
            end else if (step) begin
                store_reg[round_reg] <= next_key;
                w_reg                <= next_key;
                rk_out_reg           <= next_key;
                rk_idx_reg           <= round_reg;
                round_reg            <= round_reg + IDX_W'(1);
                rcon_reg             <= rcon_next;
                if (round_reg == LAST_IDX) begin
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_reg;
    assign ready    = ready_reg;
    assign rk_valid = rk_valid_reg;
    assign rk_idx   = rk_idx_reg;
    assign rk_out   = rk_out_reg;
    // Indices past the last round key read as zero rather than wrapping.
    assign rd_key   = (rd_idx <= LAST_IDX) ? store_reg[rd_idx] : '0;
endmodule
